imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 128, the instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the byte address of the first loaded word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, an asynchronous, active-low reset.
REQ-005 SHALL have port byte_valid, input, 1, meaning the source presents a byte.
REQ-006 SHALL have port byte_data, input, 8, the presented byte.
REQ-007 SHALL have port byte_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1, the instruction memory write strobe.
REQ-009 SHALL have port mem_addr, output, 32, the instruction memory byte address.
REQ-010 SHALL have port mem_wdata, output, 32, the instruction word to write.
REQ-011 SHALL have port cpu_hold, output, 1, which holds the CPU program counter in reset while high.
REQ-012 SHALL have port load_done, output, 1, meaning the image loaded successfully.
REQ-013 SHALL have port load_err, output, 1, meaning the image was rejected.

Function
REQ-014 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both 1.
REQ-015 SHALL use this stream format:
- count high byte, then count low byte, forming a 16-bit word count N;
- then N words, each big-endian (first byte goes to [31:24]).
REQ-016 SHALL implement states CNT_HI, CNT_LO, DATA, WRITE, DONE and ERR.
REQ-017 SHALL assert byte_ready=1 in CNT_HI, CNT_LO and DATA, and byte_ready=0 in WRITE, DONE and ERR.
REQ-018 SHALL, from CNT_LO on acceptance, go to:
- DONE if N==0;
- ERR if N>MAX_WORDS;
- otherwise DATA.
REQ-019 SHALL go from DATA to WRITE on acceptance of the 4th byte of a word.
REQ-020 SHALL drive mem_we=1 for exactly one cycle (the WRITE cycle), which is the cycle after the 4th byte is accepted.
REQ-021 SHALL hold mem_wdata and mem_addr stable during the WRITE cycle, with mem_addr = BASE_ADDR + 4*k for word index k (0-based).
REQ-022 SHALL leave WRITE as follows: to DATA if k+1<N; otherwise to DONE.
REQ-023 SHALL treat DONE and ERR as terminal, left only by reset; bytes offered in these states are never accepted.
REQ-024 SHALL drive cpu_hold=1 in every state except DONE, where it is 0 starting the cycle DONE is entered.
REQ-025 SHALL drive load_done=1 only in DONE and load_err=1 only in ERR.
REQ-026 SHALL wrap the byte-lane counter modulo 4, and the word index never exceeds MAX_WORDS-1.
REQ-027 SHALL allow arbitrary idle cycles (byte_valid=0) between bytes without affecting state.

Reset
REQ-028 SHALL, on reset=0, immediately enter CNT_HI with byte_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, and clear all counters.
REQ-029 SHALL, on reset asserted mid-word or mid-write, abandon the partial word with no write strobe, and restart the load from CNT_HI.

Configuration
REQ-030 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, use the checksum behaviour:
- a CSUM state (byte_ready=1) follows the last WRITE;
- the accepted byte is compared with the XOR of all data bytes;
- match goes to DONE, mismatch goes to ERR;
- for N==0 the expected checksum is 8'h00.
REQ-031 SHALL, without IMEM_LOADER_CHECKSUM_EN, contain no CSUM state and no XOR logic, with the last WRITE going directly to DONE.

Structure
REQ-032 SHALL place the state enumeration typedef and the header length constant (2 bytes) in the shared package cpu_pkg.
REQ-033 SHALL be a single flat module with no sub-module, since byte assembly is a 4-lane shift register inside it.

Verification
REQ-034 SHALL pass these directed scenarios:
- Stream 00 02 24 08 00 05 00 00 00 00 (BASE_ADDR=0) -> two mem_we pulses: addr 0 data 32'h2408_0005, then addr 4 data 32'h0000_0000; load_done=1; cpu_hold falls.
- Stream 00 00 -> DONE with no mem_we; with checksum enabled, a further byte 00 is needed, and byte 01 instead gives load_err=1.
- Stream 00 81 with MAX_WORDS=128 -> load_err=1, byte_ready=0, cpu_hold stays 1, and no writes occur.
- Single word 12 34 56 78 with byte_valid toggling every other cycle -> one write of 32'h1234_5678; byte_ready=0 for exactly the WRITE cycle.
- reset pulled low after 2 data bytes, then stream 00 01 AA BB CC DD -> exactly one write, addr 0, data 32'hAABB_CCDD.
- Checksum enabled, stream 00 01 01 02 04 08 0F -> DONE; the same with a final byte 0E -> ERR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared loader types: FSM state encoding and stream header length.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

  localparam int unsigned HDR_BYTES = 2;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ERR,
    CSUM
`else
    ERR
`endif
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream boot loader: reads a 16-bit word count, then big-endian words, into instruction memory.
// Optional IMEM_LOADER_CHECKSUM_EN appends a trailing XOR checksum byte.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CNT_W = 8 * HDR_BYTES;
  localparam logic [CNT_W:0] MAX_N = (CNT_W + 1)'(MAX_WORDS);

  state_t             r_state;
  logic               r_byte_ready;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_cpu_hold;
  logic               r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_idx;
  logic [1:0]         r_lane;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_acc;
  logic [CNT_W-1:0]   w_n;
  logic               w_more;

  assign w_acc  = byte_valid & r_byte_ready;
  assign w_n    = {r_cnt[CNT_W-1:8], byte_data};
  assign w_more = ({1'b0, r_idx} + (CNT_W + 1)'(1)) < {1'b0, r_cnt};

  // Outputs are registered alongside the state, so each branch sets them for the state it enters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= CNT_HI;
      r_byte_ready <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_wdata      <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_lane       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        CNT_HI: begin
          if (w_acc) begin
            r_cnt[CNT_W-1:8] <= byte_data;
            r_state          <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (w_acc) begin
            r_cnt[7:0] <= byte_data;
            if (w_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state      <= CSUM;
`else
              r_state      <= DONE;
              r_byte_ready <= 1'b0;
              r_cpu_hold   <= 1'b0;
              r_done       <= 1'b1;
`endif
            end else if ({1'b0, w_n} > MAX_N) begin
              r_state      <= ERR;
              r_byte_ready <= 1'b0;
              r_err        <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_acc) begin
            r_wdata <= {r_wdata[23:0], byte_data};
            r_lane  <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ byte_data;
`endif
            if (r_lane == 2'd3) begin
              r_state      <= WRITE;
              r_byte_ready <= 1'b0;
              r_we         <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_more) begin
            r_idx        <= r_idx + CNT_W'(1);
            r_addr       <= r_addr + 32'd4;
            r_state      <= DATA;
            r_byte_ready <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state      <= CSUM;
            r_byte_ready <= 1'b1;
`else
            r_state      <= DONE;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (w_acc) begin
            r_byte_ready <= 1'b0;
            if (byte_data == r_csum) begin
              r_state    <= DONE;
              r_cpu_hold <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= ERR;
              r_err      <= 1'b1;
            end
          end
        end
`endif
        default: begin
          // DONE and ERR are terminal until reset.
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; expectations follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  imem_loader #(
    .MAX_WORDS(128),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  logic [31:0] wa [64];
  logic [31:0] wd [64];
  int nwr = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1 && nwr < 64) begin
      wa[nwr] <= mem_addr;
      wd[nwr] <= mem_wdata;
      nwr     <= nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    byte_valid = 1'b0;
    chk($sformatf("accept_%h", b), 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;

    // reset values, checked while reset is still low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_we",    32'(mem_we),     32'd0);
    chk("rst_addr",  mem_addr,        32'h0);
    chk("rst_wdata", mem_wdata,       32'h0);
    chk("rst_hold",  32'(cpu_hold),   32'd1);
    chk("rst_done",  32'(load_done),  32'd0);
    chk("rst_err",   32'(load_err),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // two-word image
    base = nwr;
    send(8'h00); send(8'h02);
    chk("s1_hold_loading", 32'(cpu_hold), 32'd1);
    send(8'h24); send(8'h08); send(8'h00); send(8'h05);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h29);
`endif
    idle(2);
    chk("s1_nwr",   32'(nwr - base), 32'd2);
    chk("s1_addr0", wa[base],        32'h0000_0000);
    chk("s1_data0", wd[base],        32'h2408_0005);
    chk("s1_addr1", wa[base+1],      32'h0000_0004);
    chk("s1_data1", wd[base+1],      32'h0000_0000);
    chk("s1_done",  32'(load_done),  32'd1);
    chk("s1_hold",  32'(cpu_hold),   32'd0);
    chk("s1_ready", 32'(byte_ready), 32'd0);
    chk("s1_err",   32'(load_err),   32'd0);

    // empty image
    rst_pulse();
    base = nwr;
    send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("s2_csum_wait_done",  32'(load_done),  32'd0);
    chk("s2_csum_wait_ready", 32'(byte_ready), 32'd1);
    send(8'h00);
`endif
    idle(1);
    chk("s2_done", 32'(load_done),   32'd1);
    chk("s2_hold", 32'(cpu_hold),    32'd0);
    chk("s2_nwr",  32'(nwr - base),  32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    rst_pulse();
    send(8'h00); send(8'h00); send(8'h01);
    idle(1);
    chk("s2_badcsum_err",  32'(load_err),  32'd1);
    chk("s2_badcsum_done", 32'(load_done), 32'd0);
`endif

    // oversize count rejected, and the largest legal count accepted
    rst_pulse();
    base = nwr;
    send(8'h00); send(8'h81);
    idle(1);
    chk("s3_err",   32'(load_err),   32'd1);
    chk("s3_ready", 32'(byte_ready), 32'd0);
    chk("s3_hold",  32'(cpu_hold),   32'd1);
    chk("s3_done",  32'(load_done),  32'd0);
    idle(3);
    chk("s3_nwr",   32'(nwr - base), 32'd0);
    rst_pulse();
    send(8'h00); send(8'h80);
    idle(1);
    chk("s3_max_err",   32'(load_err),   32'd0);
    chk("s3_max_ready", 32'(byte_ready), 32'd1);

    // single word with idle gaps between bytes
    rst_pulse();
    base = nwr;
    send(8'h00); idle(1); send(8'h01); idle(1);
    send(8'h12); idle(1); send(8'h34); idle(1); send(8'h56); idle(1);
    chk("s4_ready_data", 32'(byte_ready), 32'd1);
    send(8'h78);
    chk("s4_ready_write", 32'(byte_ready), 32'd0);
    chk("s4_we_write",    32'(mem_we),     32'd1);
    chk("s4_wdata",       mem_wdata,       32'h1234_5678);
    chk("s4_addr",        mem_addr,        32'h0000_0000);
    idle(1);
    chk("s4_we_after", 32'(mem_we), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("s4_ready_after", 32'(byte_ready), 32'd1);
    send(8'h08);
`else
    chk("s4_ready_after", 32'(byte_ready), 32'd0);
`endif
    idle(1);
    chk("s4_nwr",  32'(nwr - base),  32'd1);
    chk("s4_done", 32'(load_done),   32'd1);

    // reset mid-word, then a clean load
    rst_pulse();
    base = nwr;
    send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    reset = 1'b0;
    #1;
    chk("s5_rst_we",    32'(mem_we),     32'd0);
    chk("s5_rst_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(8'h00); send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    idle(2);
    chk("s5_nwr",  32'(nwr - base), 32'd1);
    chk("s5_addr", wa[base],        32'h0000_0000);
    chk("s5_data", wd[base],        32'hAABB_CCDD);
    chk("s5_done", 32'(load_done),  32'd1);

    // reset during the write cycle suppresses the strobe
    rst_pulse();
    base = nwr;
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("s5w_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("s5w_we_rst", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    chk("s5w_nwr",   32'(nwr - base),  32'd0);
    chk("s5w_ready", 32'(byte_ready),  32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum over 01 02 04 08 is 0F
    rst_pulse();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0F);
    idle(1);
    chk("s6_good_done", 32'(load_done), 32'd1);
    chk("s6_good_err",  32'(load_err),  32'd0);
    rst_pulse();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0E);
    idle(1);
    chk("s6_bad_err",  32'(load_err),  32'd1);
    chk("s6_bad_done", 32'(load_done), 32'd0);
    chk("s6_bad_hold", 32'(cpu_hold),  32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
